// File: rtl/gol_grid_engine.sv
// Game of Life engine: a GRID_H x GRID_W grid evolving under B3/S23 rules.
// Generations advance every `period` frame ticks while running, or once per step
// edge while paused. The display reads `cells` directly.
module gol_grid_engine #(
  parameter int unsigned GRID_W       = 20,
  parameter int unsigned GRID_H       = 20,
  parameter int unsigned WRAP         = 0,
  parameter int unsigned BASE_FRAMES  = 200,
  parameter int unsigned FRAME_STEP   = 50,
  parameter int unsigned SPEED_LEVELS = 4,
  parameter int unsigned GEN_W        = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load,
  input  logic [GRID_W*GRID_H-1:0]        seed,
  input  logic                            frame_tick,
  input  logic                            speed_btn,
  input  logic                            run,
  input  logic                            step,
  output logic [GRID_W*GRID_H-1:0]        cells,
  output logic [GEN_W-1:0]                gen_count,
  output logic                            gen_pulse,
  output logic                            stable,
  output logic                            extinct,
  output logic [$clog2(SPEED_LEVELS)-1:0] speed_level
);

  localparam int unsigned NCELL = GRID_W * GRID_H;
  localparam int unsigned IW    = $clog2(NCELL);
  localparam int unsigned FW    = $clog2(BASE_FRAMES);
  localparam int unsigned SW    = $clog2(SPEED_LEVELS);
  localparam int          GH    = int'(GRID_H);
  localparam int          GW    = int'(GRID_W);

  logic [NCELL-1:0] cells_q, cells_d, next_cells;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             pulse_q, pulse_d;
  logic             stable_q, stable_d;
  logic [SW-1:0]    speed_q, speed_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic             step_q;
  logic             btn_q;

  logic             step_edge, btn_edge;
  logic [FW-1:0]    period_m1;
  logic             tick_commit, commit;

  int               rr, cc;
  logic [3:0]       nbr;

  // Neighbour count and B3/S23 rule for every cell, from the registered grid.
  always_comb begin
    next_cells = '0;
    rr         = 0;
    cc         = 0;
    nbr        = '0;
    for (int r = 0; r < GH; r++) begin
      for (int c = 0; c < GW; c++) begin
        nbr = '0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = r + dr;
              cc = c + dc;
              if (WRAP != 0) begin
                rr = (rr + GH) % GH;
                cc = (cc + GW) % GW;
              end
              if (rr >= 0 && rr < GH && cc >= 0 && cc < GW) begin
                nbr = nbr + 4'(cells_q[IW'(rr * GW + cc)]);
              end
            end
          end
        end
        next_cells[IW'(r * GW + c)] = (nbr == 4'd3) |
                                      (cells_q[IW'(r * GW + c)] & (nbr == 4'd2));
      end
    end
  end

  // Commit decision: frame-paced while running, step-edge paced while paused.
  always_comb begin
    step_edge   = step & ~step_q;
    btn_edge    = speed_btn & ~btn_q;
    period_m1   = FW'(BASE_FRAMES - 1 - 32'(speed_q) * FRAME_STEP);
    // >= so a shorter period after a speed change commits on the very next tick
    tick_commit = run & frame_tick & (fcnt_q >= period_m1);
    commit      = tick_commit | (~run & step_edge);
  end

  // Next-state for grid, counters and status; load overrides any commit.
  always_comb begin
    cells_d  = cells_q;
    gen_d    = gen_q;
    pulse_d  = 1'b0;
    stable_d = stable_q;
    fcnt_d   = fcnt_q;
    speed_d  = speed_q;

    if (btn_edge) begin
      speed_d = (32'(speed_q) == SPEED_LEVELS - 1) ? '0 : speed_q + 1'b1;
    end

    if (run && frame_tick) begin
      fcnt_d = tick_commit ? '0 : fcnt_q + 1'b1;
    end

    if (load) begin
      cells_d  = seed;
      gen_d    = '0;
      stable_d = 1'b0;
      fcnt_d   = '0;
    end else if (commit) begin
      cells_d  = next_cells;
      gen_d    = gen_q + 1'b1;
      stable_d = (next_cells == cells_q);
      pulse_d  = 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cells_q  <= '0;
      gen_q    <= '0;
      pulse_q  <= 1'b0;
      stable_q <= 1'b0;
      speed_q  <= '0;
      fcnt_q   <= '0;
      step_q   <= 1'b0;
      btn_q    <= 1'b0;
    end else begin
      cells_q  <= cells_d;
      gen_q    <= gen_d;
      pulse_q  <= pulse_d;
      stable_q <= stable_d;
      speed_q  <= speed_d;
      fcnt_q   <= fcnt_d;
      step_q   <= step;
      btn_q    <= speed_btn;
    end
  end

  // Output mapping.
  always_comb begin
    cells       = cells_q;
    gen_count   = gen_q;
    gen_pulse   = pulse_q;
    stable      = stable_q;
    extinct     = ~|cells_q;
    speed_level = speed_q;
  end

endmodule
